// File: rtl/serial_fixed_adder_pkg.sv
// Shared fixed-point constants and FSM state encoding for the serial arithmetic stages.
`timescale 1ns/1ps
package serial_fixed_adder_pkg;

  localparam int FP_WIDTH   = 32;
  localparam int DIGIT_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int digit_count(input int width);
    return width / DIGIT_BITS;
  endfunction

endpackage

// File: rtl/serial_fixed_adder_if.sv
// Operand/result handshake bundle between the integrator control and the serial adder.
`timescale 1ns/1ps
interface serial_fixed_adder_if
  import serial_fixed_adder_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_op_a;
  logic [WIDTH-1:0] i_op_b;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_overflow;

  modport master (
    output i_valid, i_op_a, i_op_b, i_sub, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_overflow
  );

  modport slave (
    input  i_valid, i_op_a, i_op_b, i_sub, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_overflow
  );

endinterface

// File: rtl/serial_fixed_adder_adder_block.sv
// One-digit (2-bit) ripple adder; also exposes the carry into the upper bit for overflow detection.
`timescale 1ns/1ps
module adder_block
  import serial_fixed_adder_pkg::*;
(
  input  logic [DIGIT_BITS-1:0] a_i,
  input  logic [DIGIT_BITS-1:0] b_i,
  input  logic                  cin_i,
  output logic [DIGIT_BITS:0]   result_o,
  output logic                  intermediate_carry_o
);

  logic [DIGIT_BITS:0] carry;

  assign carry[0] = cin_i;

  generate
    for (genvar gi = 0; gi < DIGIT_BITS; gi++) begin : g_bit
      assign result_o[gi]  = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign result_o[DIGIT_BITS]  = carry[DIGIT_BITS];
  assign intermediate_carry_o  = carry[DIGIT_BITS-1];

endmodule

// File: rtl/serial_fixed_adder.sv
// Digit-serial two's-complement add/subtract: feeds one 2-bit digit per cycle through
// adder_block and presents the wrapped result with carry and signed-overflow flags.
`timescale 1ns/1ps
module serial_fixed_adder
  import serial_fixed_adder_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
)
(
  input  logic                i_clk,
  input  logic                i_rst,
  serial_fixed_adder_if.slave bus
);

  localparam int            DIGITS = digit_count(WIDTH);
  localparam int            CW     = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST   = CW'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT_BITS:0] digit_sum;
  logic                int_carry;

  adder_block u_adder_block (
    .a_i                  (a_q[DIGIT_BITS-1:0]),
    .b_i                  (b_q[DIGIT_BITS-1:0]),
    .cin_i                (cy_q),
    .result_o             (digit_sum),
    .intermediate_carry_o (int_carry)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = bus.i_op_a;
          b_d     = bus.i_sub ? ~bus.i_op_b : bus.i_op_b;
          cy_d    = bus.i_sub;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cy_d  = digit_sum[DIGIT_BITS];
        acc_d = {digit_sum[DIGIT_BITS-1:0], acc_q[WIDTH-1:DIGIT_BITS]};
        a_d   = a_q >> DIGIT_BITS;
        b_d   = b_q >> DIGIT_BITS;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Outputs are only updated here so they stay frozen while the next operand streams.
          res_d   = acc_d;
          carry_d = digit_sum[DIGIT_BITS];
          ovf_d   = digit_sum[DIGIT_BITS] ^ int_carry;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_ready    = (state_q == ST_IDLE);
  assign bus.o_valid    = (state_q == ST_DONE);
  assign bus.o_result   = res_q;
  assign bus.o_carry    = carry_q;
  assign bus.o_overflow = ovf_q;

endmodule
